// File: rtl/i2c_byte_master_if.sv
// ----------------------------------------------------------------------------
// i2c_byte_master_if
//   Bundles the command/response handshake and the open-drain line pair of
//   the byte-level I2C master so the engine can be bound as one port.
//
//   Handshake semantics (valid/ready):
//     A command transfers on a rising clock edge where cmd_valid_i and
//     cmd_ready_o are both 1. The master drops cmd_ready_o the cycle after
//     the transfer and raises it again in the cycle where rsp_valid_o pulses,
//     so exactly one command is in flight and exactly one response per
//     command is returned. rsp_valid_o is a single-cycle pulse with no
//     back-pressure; rsp_ack_o/rsp_err_o read 0 outside that pulse.
//
//   Signals (names seen from the master):
//     cmd_valid_i, cmd_i[2:0], wdata_i   command in
//     cmd_ready_o                        master can take a command
//     rsp_valid_o, rsp_ack_o, rsp_err_o  response pulse and its flags
//     rsp_rdata_o                        last byte read, held
//     busy_o                             bus owned (between START and STOP)
//     scl_i, sda_i                       sampled line levels
//     scl_o, sda_o                       1 = release, 0 = pull low
//     dbg_state_o                        engine state for observation
//
//   Modports: master (the engine), slave (upstream controller + pad side).
// ----------------------------------------------------------------------------
interface i2c_byte_master_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  cmd_valid_i;
  logic                  cmd_ready_o;
  logic [2:0]            cmd_i;
  logic [DATA_WIDTH-1:0] wdata_i;
  logic                  rsp_valid_o;
  logic                  rsp_ack_o;
  logic                  rsp_err_o;
  logic [DATA_WIDTH-1:0] rsp_rdata_o;
  logic                  busy_o;
  logic                  scl_i;
  logic                  sda_i;
  logic                  scl_o;
  logic                  sda_o;
  logic [2:0]            dbg_state_o;

  modport master (
    input  cmd_valid_i, cmd_i, wdata_i, scl_i, sda_i,
    output cmd_ready_o, rsp_valid_o, rsp_ack_o, rsp_err_o, rsp_rdata_o,
           busy_o, scl_o, sda_o, dbg_state_o
  );

  modport slave (
    output cmd_valid_i, cmd_i, wdata_i, scl_i, sda_i,
    input  cmd_ready_o, rsp_valid_o, rsp_ack_o, rsp_err_o, rsp_rdata_o,
           busy_o, scl_o, sda_o, dbg_state_o
  );
endinterface

// File: rtl/i2c_byte_master.sv
// ----------------------------------------------------------------------------
// i2c_byte_master
//   Byte-level I2C master. Takes START / STOP / WRITE / READ_ACK / READ_NACK
//   commands and serialises them onto open-drain SCL/SDA, returning one
//   response per command (slave ACK, read byte or error flag).
//
//   Parameters:
//     QDIV        clk_i cycles per quarter bit-period (>= 2)
//     DATA_WIDTH  bits per byte, fixed at 8
//
//   Ports:
//     clk_i   system clock
//     rst_i   synchronous active-low reset
//     bus     i2c_byte_master_if.master: command/response handshake,
//             busy flag, sampled lines, line drives, debug state
//
//   Build option:
//     I2C_CLK_STRETCH_EN  when defined, the quarter counter holds during
//                         phase C while SCL is released but still reads
//                         low (slave clock stretching). When undefined,
//                         scl_i is ignored and timing is purely QDIV-based.
//
//   Opcodes: 000 START, 001 STOP, 010 WRITE, 011 READ_ACK, 100 READ_NACK.
//
//   Every bus sequence is a chain of four quarter phases A..D, each QDIV
//   cycles long. Line values are registered and updated on the edge that
//   enters a phase, so each phase's line action is visible for the whole
//   phase. A byte is eight BIT sequences (MSB first) plus one ACKBIT.
// ----------------------------------------------------------------------------
module i2c_byte_master #(
  parameter int QDIV       = 250,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  i2c_byte_master_if.master     bus
);

  localparam int CW = (QDIV > 2) ? $clog2(QDIV) : 1;
  localparam logic [CW-1:0] CNT_RELOAD = CW'(QDIV - 1);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_STOP   = 3'd2;
  localparam logic [2:0] ST_BIT    = 3'd3;
  localparam logic [2:0] ST_ACKBIT = 3'd4;
  localparam logic [2:0] ST_DONE   = 3'd5;

  localparam logic [1:0] PH_A = 2'd0;
  localparam logic [1:0] PH_B = 2'd1;
  localparam logic [1:0] PH_C = 2'd2;
  localparam logic [1:0] PH_D = 2'd3;

  localparam logic [2:0] CMD_START     = 3'b000;
  localparam logic [2:0] CMD_STOP      = 3'b001;
  localparam logic [2:0] CMD_WRITE     = 3'b010;
  localparam logic [2:0] CMD_READ_ACK  = 3'b011;
  localparam logic [2:0] CMD_READ_NACK = 3'b100;

  logic [2:0]            st_q, st_d;
  logic [1:0]            ph_q, ph_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [2:0]            bit_q, bit_d;
  logic [2:0]            cmd_q, cmd_d;
  logic [DATA_WIDTH-1:0] sh_q, sh_d;
  logic                  ack_q, ack_d;
  logic                  err_q, err_d;
  logic                  busy_q, busy_d;
  logic                  ready_q, ready_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic                  rsp_ack_q, rsp_ack_d;
  logic                  rsp_err_q, rsp_err_d;
  logic                  scl_q, scl_d;
  logic                  sda_q, sda_d;

  // Set on every edge that enters a new phase (or DONE); gates line updates.
  logic                  enter;
  // Quarter counter freeze request (clock stretching only).
  logic                  hold;
  // SDA value for phase A of the bit being entered.
  logic                  drive_bit;

`ifdef I2C_CLK_STRETCH_EN
  // SCL is released in every phase C; a low read-back there means a slave
  // is stretching the clock, so the phase is extended until it lets go.
  assign hold = (ph_q == PH_C) && scl_q && !bus.scl_i;
`else
  assign hold = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Sequencer: state, phase, quarter counter, shift register, response.
  // --------------------------------------------------------------------------
  always_comb begin
    st_d        = st_q;
    ph_d        = ph_q;
    cnt_d       = cnt_q;
    bit_d       = bit_q;
    cmd_d       = cmd_q;
    sh_d        = sh_q;
    ack_d       = ack_q;
    err_d       = err_q;
    busy_d      = busy_q;
    ready_d     = ready_q;
    rdata_d     = rdata_q;
    rsp_valid_d = 1'b0;
    rsp_ack_d   = 1'b0;
    rsp_err_d   = 1'b0;
    enter       = 1'b0;

    case (st_q)
      ST_IDLE: begin
        if (bus.cmd_valid_i && ready_q) begin
          ready_d = 1'b0;
          cmd_d   = bus.cmd_i;
          sh_d    = bus.wdata_i;
          ack_d   = 1'b0;
          err_d   = 1'b0;
          ph_d    = PH_A;
          cnt_d   = CNT_RELOAD;
          bit_d   = 3'd7;
          enter   = 1'b1;
          case (bus.cmd_i)
            CMD_START: st_d = ST_START;
            CMD_STOP: begin
              if (busy_q) begin
                st_d = ST_STOP;
              end else begin
                st_d  = ST_DONE;
                err_d = 1'b1;
              end
            end
            CMD_WRITE, CMD_READ_ACK, CMD_READ_NACK: begin
              if (busy_q) begin
                st_d = ST_BIT;
              end else begin
                st_d  = ST_DONE;
                err_d = 1'b1;
              end
            end
            default: begin
              st_d  = ST_DONE;
              err_d = 1'b1;
            end
          endcase
        end
      end

      ST_START, ST_STOP, ST_BIT, ST_ACKBIT: begin
        if (!hold) begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
          end else begin
            cnt_d = CNT_RELOAD;
            enter = 1'b1;
            // Last clock of phase C: SCL has been high for a full quarter,
            // so SDA is stable and gets sampled here.
            if (ph_q == PH_C) begin
              if (st_q == ST_BIT) begin
                sh_d = {sh_q[DATA_WIDTH-2:0], bus.sda_i};
              end
              if (st_q == ST_ACKBIT) begin
                ack_d = (cmd_q == CMD_WRITE) && !bus.sda_i;
              end
            end
            if (ph_q != PH_D) begin
              ph_d = ph_q + 2'd1;
            end else begin
              ph_d = PH_A;
              case (st_q)
                ST_BIT: begin
                  if (bit_q == 3'd0) begin
                    st_d = ST_ACKBIT;
                  end else begin
                    bit_d = bit_q - 3'd1;
                  end
                end
                default: st_d = ST_DONE;
              endcase
            end
          end
        end
      end

      ST_DONE: begin
        st_d        = ST_IDLE;
        ready_d     = 1'b1;
        rsp_valid_d = 1'b1;
        rsp_err_d   = err_q;
        rsp_ack_d   = ack_q;
        if (!err_q) begin
          case (cmd_q)
            CMD_START:                   busy_d  = 1'b1;
            CMD_STOP:                    busy_d  = 1'b0;
            CMD_READ_ACK, CMD_READ_NACK: rdata_d = sh_q;
            default: ;
          endcase
        end
      end

      default: st_d = ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Line drives: actions belong to the phase being entered. Lines not named
  // by a phase keep their value.
  // --------------------------------------------------------------------------
  always_comb begin
    drive_bit = 1'b1;
    if (st_d == ST_BIT) begin
      drive_bit = (cmd_d == CMD_WRITE) ? sh_d[DATA_WIDTH-1] : 1'b1;
    end else if (st_d == ST_ACKBIT) begin
      // Master acknowledges a read byte by pulling SDA low; a write's
      // ninth bit is left released for the slave.
      drive_bit = (cmd_d == CMD_READ_ACK) ? 1'b0 : 1'b1;
    end
  end

  always_comb begin
    scl_d = scl_q;
    sda_d = sda_q;
    if (enter) begin
      case (st_d)
        ST_START: begin
          case (ph_d)
            PH_A:    sda_d = 1'b1;
            PH_B:    scl_d = 1'b1;
            PH_C:    sda_d = 1'b0;
            default: scl_d = 1'b0;
          endcase
        end
        ST_STOP: begin
          case (ph_d)
            PH_A: begin
              sda_d = 1'b0;
              scl_d = 1'b0;
            end
            PH_B:    scl_d = 1'b1;
            PH_C:    sda_d = 1'b1;
            default: ;
          endcase
        end
        ST_BIT, ST_ACKBIT: begin
          case (ph_d)
            PH_A: begin
              scl_d = 1'b0;
              sda_d = drive_bit;
            end
            PH_B:    scl_d = 1'b0;
            default: scl_d = 1'b1;
          endcase
        end
        ST_DONE: begin
          // Park after a byte with SCL low and SDA released, so the next
          // byte, STOP or repeated START starts from a known line state.
          if (st_q == ST_ACKBIT) begin
            scl_d = 1'b0;
            sda_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Registers. Reset abandons any transfer in progress without a STOP.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      st_q        <= ST_IDLE;
      ph_q        <= PH_A;
      cnt_q       <= CNT_RELOAD;
      bit_q       <= 3'd7;
      cmd_q       <= CMD_START;
      sh_q        <= '0;
      ack_q       <= 1'b0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
      ready_q     <= 1'b1;
      rdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_ack_q   <= 1'b0;
      rsp_err_q   <= 1'b0;
      scl_q       <= 1'b1;
      sda_q       <= 1'b1;
    end else begin
      st_q        <= st_d;
      ph_q        <= ph_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      cmd_q       <= cmd_d;
      sh_q        <= sh_d;
      ack_q       <= ack_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
      ready_q     <= ready_d;
      rdata_q     <= rdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_ack_q   <= rsp_ack_d;
      rsp_err_q   <= rsp_err_d;
      scl_q       <= scl_d;
      sda_q       <= sda_d;
    end
  end

  assign bus.cmd_ready_o = ready_q;
  assign bus.rsp_valid_o = rsp_valid_q;
  assign bus.rsp_ack_o   = rsp_ack_q;
  assign bus.rsp_err_o   = rsp_err_q;
  assign bus.rsp_rdata_o = rdata_q;
  assign bus.busy_o      = busy_q;
  assign bus.scl_o       = scl_q;
  assign bus.sda_o       = sda_q;
  assign bus.dbg_state_o = st_q;

endmodule

// File: tb/tb_i2c_byte_master.sv
// ----------------------------------------------------------------------------
// tb_i2c_byte_master
//   Drives commands into i2c_byte_master (QDIV=4) against a small I2C slave
//   model at address 0x22, checks responses through an expected queue and
//   observes what the slave saw on the wires.
// ----------------------------------------------------------------------------
module tb_i2c_byte_master;

  localparam int QDIV   = 4;
  localparam int W      = 10;
  localparam int L_SEQ  = 4 * QDIV + 1;
  localparam int L_BYTE = 36 * QDIV + 1;
  localparam logic [6:0] BFM_ADDR = 7'h22;

  localparam logic [2:0] C_START = 3'b000;
  localparam logic [2:0] C_STOP  = 3'b001;
  localparam logic [2:0] C_WRITE = 3'b010;
  localparam logic [2:0] C_RACK  = 3'b011;
  localparam logic [2:0] C_RNACK = 3'b100;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  i2c_byte_master_if #(.DATA_WIDTH(8)) bus ();

  i2c_byte_master #(.QDIV(QDIV), .DATA_WIDTH(8)) dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bus)
  );

  // ---------------- wired-AND lines ----------------
  logic bfm_sda = 1'b1;
  logic stretch_arm = 1'b0;
  int   scnt = 0;
  logic stretch;
  assign stretch    = stretch_arm && bus.scl_o && (scnt != 0);
  assign bus.scl_i  = bus.scl_o & ~stretch;
  assign bus.sda_i  = bus.sda_o & bfm_sda;

  always @(negedge clk) if (stretch) scnt <= scnt - 1;

  // ---------------- checker ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- slave model ----------------
  logic       scl_p = 1'b1, sda_p = 1'b1;
  int         bcnt = 0, bmode = 0;
  bit         active = 0, mack = 0, bfm_drove = 0;
  int         starts = 0, restarts = 0, stops = 0;
  logic [7:0] bsh = '0, rd_byte = '0, last_addr = '0;
  logic [7:0] rd_src[$];
  logic [7:0] wr_seen[$];
  logic       mack_seen[$];

  always @(negedge clk) begin
    logic scl_l, sda_l;
    scl_l = bus.scl_i;
    sda_l = bus.sda_i;
    if (scl_p && scl_l && sda_p && !sda_l) begin
      if (active) restarts++;
      starts++;
      active = 1; bmode = 1; bcnt = 0; bfm_sda = 1'b1;
    end else if (scl_p && scl_l && !sda_p && sda_l) begin
      stops++;
      active = 0; bmode = 0; bfm_sda = 1'b1;
    end else if (active) begin
      if (!scl_p && scl_l) begin
        if (bcnt < 8) bsh = {bsh[6:0], sda_l};
        else if (bmode == 3) begin
          mack = ~sda_l;
          mack_seen.push_back(mack);
        end
        bcnt++;
      end else if (scl_p && !scl_l) begin
        if (bcnt == 8) begin
          case (bmode)
            1: begin
              last_addr = bsh;
              bfm_sda = (bsh[7:1] == BFM_ADDR) ? 1'b0 : 1'b1;
            end
            2: begin
              wr_seen.push_back(bsh);
              bfm_sda = 1'b0;
            end
            default: bfm_sda = 1'b1;
          endcase
        end else if (bcnt == 9) begin
          bcnt = 0;
          bfm_sda = 1'b1;
          if (bmode == 1) begin
            if (last_addr[7:1] != BFM_ADDR) bmode = 4;
            else if (last_addr[0]) begin
              bmode = 3;
              rd_byte = (rd_src.size() != 0) ? rd_src.pop_front() : 8'hFF;
              bfm_sda = rd_byte[7];
            end else bmode = 2;
          end else if (bmode == 3) begin
            if (mack) begin
              rd_byte = (rd_src.size() != 0) ? rd_src.pop_front() : 8'hFF;
              bfm_sda = rd_byte[7];
            end else bmode = 4;
          end
        end else if (bmode == 3) begin
          bfm_sda = rd_byte[7 - bcnt];
        end
      end
    end
    if (!bfm_sda) bfm_drove = 1;
    scl_p = scl_l;
    sda_p = sda_l;
  end

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  logic [7:0]   model_rd = 8'h00;

  always @(negedge clk) begin
    if (rst_n && bus.rsp_valid_o) begin
      if (exp_q.size() == 0) check("rsp_unexpected", 32'd1, 32'd0);
      else check("rsp", {bus.rsp_err_o, bus.rsp_ack_o, bus.rsp_rdata_o}, exp_q.pop_front());
    end
  end

  // ---------------- driver ----------------
  task automatic send_cmd(input logic [2:0] c, input logic [7:0] d,
                          input logic e_err, input logic e_ack, input int e_lat);
    int acc, t;
    bit got;
    exp_q.push_back({e_err, e_ack, model_rd});
    t = 0;
    while (!bus.cmd_ready_o && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("cmd_ready_idle", bus.cmd_ready_o, 1'b1);
    bus.cmd_i = c;
    bus.wdata_i = d;
    bus.cmd_valid_i = 1'b1;
    @(negedge clk);
    acc = cyc;
    bus.cmd_valid_i = 1'b0;
    check("cmd_ready_fall", bus.cmd_ready_o, 1'b0);
    got = 0;
    t = 0;
    while (!got && t < 2000) begin
      if (bus.rsp_valid_o) got = 1;
      else begin
        @(negedge clk);
        t++;
      end
    end
    if (!got) begin
      check("rsp_timeout", 32'd0, 32'd1);
      void'(exp_q.pop_back());
    end else begin
      if (e_lat >= 0) check("latency", cyc - acc, e_lat);
      check("cmd_ready_rise", bus.cmd_ready_o, 1'b1);
    end
  endtask

  task automatic idle_gap();
    repeat ($urandom_range(1, 5)) @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int r0;
    logic [7:0] d;
    bus.cmd_valid_i = 1'b0;
    bus.cmd_i = 3'b000;
    bus.wdata_i = 8'h00;

    // reset state
    repeat (3) @(negedge clk);
    check("rst_scl", bus.scl_o, 1'b1);
    check("rst_sda", bus.sda_o, 1'b1);
    check("rst_ready", bus.cmd_ready_o, 1'b1);
    check("rst_rsp", {bus.rsp_valid_o, bus.rsp_ack_o, bus.rsp_err_o}, 3'b000);
    check("rst_rdata", bus.rsp_rdata_o, 8'h00);
    check("rst_busy", bus.busy_o, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    // errors while the bus is not owned
    send_cmd(C_WRITE, 8'h44, 1'b1, 1'b0, 1);
    check("err_wr_lines", {bus.scl_o, bus.sda_o}, 2'b11);
    idle_gap();
    send_cmd(C_STOP, 8'h00, 1'b1, 1'b0, -1);
    check("err_stop_lines", {bus.scl_o, bus.sda_o}, 2'b11);
    check("err_stop_nostop", stops, 0);
    send_cmd(3'b111, 8'h00, 1'b1, 1'b0, 1);
    check("err_busy", bus.busy_o, 1'b0);

    // START + address write, then random data bytes
    send_cmd(C_START, 8'h00, 1'b0, 1'b0, L_SEQ);
    check("start_busy", bus.busy_o, 1'b1);
    check("start_lines", {bus.scl_o, bus.sda_o}, 2'b00);
    check("start_seen", starts, 1);
    send_cmd(C_WRITE, 8'h44, 1'b0, 1'b1, L_BYTE);
    check("addr_seen", last_addr, 8'h44);
    check("byte_end_lines", {bus.scl_o, bus.sda_o}, 2'b01);
    for (int i = 0; i < 3; i++) begin
      d = 8'($urandom_range(0, 255));
      idle_gap();
      send_cmd(C_WRITE, d, 1'b0, 1'b1, L_BYTE);
      if (wr_seen.size() != 0) check("wr_data", wr_seen.pop_front(), d);
      else check("wr_data_missing", 32'd0, 32'd1);
    end

    // repeated START, then a non-matching address
    r0 = restarts;
    send_cmd(C_START, 8'h00, 1'b0, 1'b0, L_SEQ);
    check("restart_seen", restarts, r0 + 1);
    check("restart_busy", bus.busy_o, 1'b1);
    bfm_drove = 0;
    send_cmd(C_WRITE, 8'h46, 1'b0, 1'b0, L_BYTE);
    check("nack_no_drive", bfm_drove, 1'b0);
    send_cmd(C_STOP, 8'h00, 1'b0, 1'b0, L_SEQ);
    check("stop_busy", bus.busy_o, 1'b0);
    check("stop_lines", {bus.scl_o, bus.sda_o}, 2'b11);
    check("stop_seen", stops, 1);

    // read two bytes
    rd_src.push_back(8'hA5);
    rd_src.push_back(8'h3C);
    idle_gap();
    send_cmd(C_START, 8'h00, 1'b0, 1'b0, L_SEQ);
    send_cmd(C_WRITE, 8'h45, 1'b0, 1'b1, L_BYTE);
    model_rd = 8'hA5;
    send_cmd(C_RACK, 8'h00, 1'b0, 1'b0, L_BYTE);
    check("rd0", bus.rsp_rdata_o, 8'hA5);
    model_rd = 8'h3C;
    send_cmd(C_RNACK, 8'h00, 1'b0, 1'b0, L_BYTE);
    check("rd1", bus.rsp_rdata_o, 8'h3C);
    send_cmd(C_STOP, 8'h00, 1'b0, 1'b0, L_SEQ);
    check("rd_stop_busy", bus.busy_o, 1'b0);
    check("rd_hold", bus.rsp_rdata_o, 8'h3C);
    check("mack_cnt", mack_seen.size(), 2);
    if (mack_seen.size() == 2) begin
      check("mack0", mack_seen.pop_front(), 1'b1);
      check("mack1", mack_seen.pop_front(), 1'b0);
    end

    // reset in the middle of bit 3 of a WRITE
    send_cmd(C_START, 8'h00, 1'b0, 1'b0, L_SEQ);
    bus.cmd_i = C_WRITE;
    bus.wdata_i = 8'h44;
    bus.cmd_valid_i = 1'b1;
    @(negedge clk);
    bus.cmd_valid_i = 1'b0;
    repeat (16 * QDIV + 6) @(negedge clk);
    check("mid_state", bus.dbg_state_o, 3'd3);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_lines", {bus.scl_o, bus.sda_o}, 2'b11);
    check("mid_rst_busy", bus.busy_o, 1'b0);
    check("mid_rst_ready", bus.cmd_ready_o, 1'b1);
    check("mid_rst_rsp", bus.rsp_valid_o, 1'b0);
    check("mid_rst_rdata", bus.rsp_rdata_o, 8'h00);
    rst_n = 1'b1;
    model_rd = 8'h00;
    @(negedge clk);

    // recovery after reset
    send_cmd(C_START, 8'h00, 1'b0, 1'b0, L_SEQ);
    send_cmd(C_WRITE, 8'h44, 1'b0, 1'b1, L_BYTE);
    send_cmd(C_STOP, 8'h00, 1'b0, 1'b0, L_SEQ);
    check("recover_busy", bus.busy_o, 1'b0);

`ifdef I2C_CLK_STRETCH_EN
    // slave holds SCL low for 20 cycles in the first phase C of a byte
    send_cmd(C_START, 8'h00, 1'b0, 1'b0, L_SEQ);
    scnt = 20;
    stretch_arm = 1'b1;
    send_cmd(C_WRITE, 8'h44, 1'b0, 1'b1, L_BYTE + 20);
    stretch_arm = 1'b0;
    send_cmd(C_STOP, 8'h00, 1'b0, 1'b0, L_SEQ);
`endif

    repeat (4) @(negedge clk);
    check("sb_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
